// File: rtl/ka10_io_pkg.sv
// Shared KA10 I/O bus definitions: device codes, CONI/CONO bit positions,
// PI level decode and paper tape frame layout.
package ka10_io_pkg;

    // Device codes as seen on ios[3:9] (9-bit octal code with the two low zero bits dropped)
    localparam logic [6:0] DEV_PTR = 7'b0010001;
    localparam logic [6:0] DEV_PTP = 7'b0010000;

    // Bus bit positions use KA10 numbering: bit 0 is the MSB, bit 35 the LSB
    localparam int unsigned BIT_BINARY = 30;
    localparam int unsigned BIT_BUSY   = 31;
    localparam int unsigned BIT_DONE   = 32;
    localparam int unsigned BIT_PIA_HI = 33;
    localparam int unsigned BIT_PIA_LO = 35;
    localparam int unsigned BIT_DATA   = 28;

    localparam int unsigned FRAME_W     = 9;
    localparam int unsigned FRAME_FEED  = 8;
    localparam int unsigned FRAME_HOLE8 = 7;

    localparam logic [FRAME_W-1:0] FEED_FRAME = 9'h100;

    typedef enum logic [1:0] {
        StIdle,
        StLoaded,
        StPunch
    } ptp_state_e;

    // One-hot PI request for levels 1..7, MSB is level 1
    function automatic logic [6:0] pi_decode(input logic [2:0] pia);
        if (pia == 3'd0) begin
            return 7'd0;
        end
        return 7'b1000000 >> (pia - 3'd1);
    endfunction

    // In binary mode only six data bits are punched and hole 8 is always set
    function automatic logic [FRAME_W-1:0] ptp_frame(input logic [7:0] pb, input logic binary);
        logic [FRAME_W-1:0] f;
        if (binary) begin
            f = '0;
            f[FRAME_HOLE8] = 1'b1;
            f[5:0] = pb[5:0];
        end else begin
            f = {1'b0, pb};
        end
        return f;
    endfunction

endpackage

// File: rtl/iob_edge.sv
// Rising-edge pulse generator for KA10 bus strobes; the pulse is registered,
// so it follows the first cycle the level is sampled high.
module iob_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/ptp_ka10.sv
// KA10 paper tape punch: DATAO words become frames handed to a host consumer,
// completions are paced by a punch-cycle timer and raise done plus a PI request.
module ptp_ka10
    import ka10_io_pkg::*;
#(
    parameter logic [6:0]  DEVCODE      = DEV_PTP,
    parameter int unsigned PUNCH_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_poweron,
    input  logic        iobus_iob_reset,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_fm_datai,
    input  logic        iobus_iob_fm_status,
    input  logic        iobus_rdi_pulse,
    input  logic [3:9]  iobus_ios,
    input  logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi_req,
    output logic [0:35] iobus_iob_out,
    input  logic        key_tape_feed,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic        fe_data_rq
);

    localparam int unsigned TW = $clog2(PUNCH_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(PUNCH_CYCLES - 1);

    logic       w_sel;
    logic       w_clr;
    logic       w_cono_clr;
    logic       w_cono_set;
    logic       w_datao_clr;
    logic       w_datao_set;
    logic [5:0] w_cono_bits;
    logic [7:0] w_data_bits;
    logic       w_unused;

    logic [2:0] r_pia;
    logic       r_done;
    logic       r_busy;
    logic       r_binary;
    logic [7:0] r_pb;

    logic [2:0] w_pia_d;
    logic       w_done_d;
    logic       w_busy_d;
    logic       w_binary_d;
    logic [7:0] w_pb_d;
    logic [FRAME_W-1:0] w_frame_d;

    ptp_state_e         r_state;
    logic [TW-1:0]      r_timer;
    logic [FRAME_W-1:0] r_frame;
    logic               r_pend;
    logic               r_rq;

    assign w_sel = (iobus_ios == DEVCODE);
    // Bus-level clears act like reset on all controller state but not on the strobe detectors
    assign w_clr = ~iobus_iob_poweron | iobus_iob_reset;

    assign w_cono_bits = iobus_iob_in[BIT_BINARY:BIT_PIA_LO];
    assign w_data_bits = iobus_iob_in[BIT_DATA:BIT_PIA_LO];

    assign w_unused = ^{iobus_rdi_pulse, iobus_iob_fm_datai, iobus_iob_in[0:BIT_DATA-1]};

    iob_edge u_edge_cono_clr (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (iobus_cono_clear & w_sel),
        .o_pulse (w_cono_clr)
    );

    iob_edge u_edge_cono_set (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (iobus_cono_set & w_sel),
        .o_pulse (w_cono_set)
    );

    iob_edge u_edge_datao_clr (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (iobus_datao_clear & w_sel),
        .o_pulse (w_datao_clr)
    );

    iob_edge u_edge_datao_set (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (iobus_datao_set & w_sel),
        .o_pulse (w_datao_set)
    );

    // Clear phases apply before set phases when both land on the same cycle
    always_comb begin
        w_pia_d    = r_pia;
        w_done_d   = r_done;
        w_busy_d   = r_busy;
        w_binary_d = r_binary;
        w_pb_d     = r_pb;
        if (w_cono_clr) begin
            w_pia_d    = 3'd0;
            w_done_d   = 1'b0;
            w_busy_d   = 1'b0;
            w_binary_d = 1'b0;
        end
        if (w_cono_set) begin
            w_binary_d = w_binary_d | w_cono_bits[5];
            w_busy_d   = w_busy_d | w_cono_bits[4];
            w_done_d   = w_done_d | w_cono_bits[3];
            w_pia_d    = w_pia_d | w_cono_bits[2:0];
        end
        if (w_datao_clr) begin
            w_pb_d   = 8'd0;
            w_done_d = 1'b0;
        end
        if (w_datao_set) begin
            w_pb_d   = w_pb_d | w_data_bits;
            w_busy_d = 1'b1;
        end
    end

    assign w_frame_d = ptp_frame(w_pb_d, w_binary_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pia    <= 3'd0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_binary <= 1'b0;
            r_pb     <= 8'd0;
            r_state  <= StIdle;
            r_timer  <= '0;
            r_frame  <= '0;
            r_pend   <= 1'b0;
            r_rq     <= 1'b0;
        end else if (w_clr) begin
            r_pia    <= 3'd0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_binary <= 1'b0;
            r_pb     <= 8'd0;
            r_state  <= StIdle;
            r_timer  <= '0;
            r_frame  <= '0;
            r_pend   <= 1'b0;
            r_rq     <= 1'b0;
        end else begin
            r_pia    <= w_pia_d;
            r_done   <= w_done_d;
            r_busy   <= w_busy_d;
            r_binary <= w_binary_d;
            r_pb     <= w_pb_d;
            unique case (r_state)
                StIdle: begin
                    if (w_datao_set) begin
                        r_frame <= w_frame_d;
                        r_state <= StLoaded;
                        r_rq    <= 1'b1;
                    end else if (key_tape_feed && !r_busy) begin
                        r_frame <= FEED_FRAME;
                        r_state <= StLoaded;
                        r_rq    <= 1'b1;
                    end
                end
                StLoaded: begin
                    // A DATAO arriving now belongs to the frame after this one
                    if (w_datao_set) begin
                        r_pend <= 1'b1;
                    end
                    if (s_read) begin
                        r_state <= StPunch;
                        r_timer <= TIMER_LOAD;
                        r_rq    <= 1'b0;
                    end
                end
                StPunch: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - TW'(1);
                        if (w_datao_set) begin
                            r_pend <= 1'b1;
                        end
                    end else if (r_pend || w_datao_set) begin
                        // Queued word goes straight out; done waits for the last frame
                        r_pend  <= 1'b0;
                        r_frame <= w_frame_d;
                        r_state <= StLoaded;
                        r_rq    <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= w_done_d | ~r_frame[FRAME_FEED];
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign fe_data_rq    = r_rq & ~w_clr;
    assign s_readdata    = fe_data_rq ? {{(32 - FRAME_W){1'b0}}, r_frame} : 32'd0;
    assign iobus_pi_req  = (r_done && !w_clr) ? pi_decode(r_pia) : 7'd0;
    assign iobus_iob_out = (w_sel && iobus_iob_fm_status && !w_clr)
                         ? {30'd0, r_binary, r_busy, r_done, r_pia} : 36'd0;

endmodule

// File: tb/tb_ptp_ka10.sv
// Bench for ptp_ka10: directed literal checks followed by a randomized run,
// every negedge compared against a frame-level behavioural model.
module tb_ptp_ka10;

    localparam int         PUNCH = 16;
    localparam logic [6:0] PTP   = 7'b0010000;
    localparam logic [6:0] PTR   = 7'b0010001;
    localparam int CC = 0;
    localparam int CS = 1;
    localparam int DC = 2;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        poweron = 1'b1;
    logic        iob_reset = 1'b0;
    logic [3:0]  stb = 4'd0;
    logic        fm_datai = 1'b0;
    logic        fm_status = 1'b0;
    logic        rdi_pulse = 1'b0;
    logic [3:9]  ios = 7'd0;
    logic [0:35] iob_in = 36'd0;
    logic [1:7]  pi_req;
    logic [0:35] iob_out;
    logic        key = 1'b0;
    logic        s_read = 1'b0;
    logic [31:0] s_readdata;
    logic        fe_data_rq;

    int n_checks = 0;
    int n_errors = 0;
    bit running = 1'b1;

    always #5 clk = ~clk;

    ptp_ka10 dut (
        .clk                 (clk),
        .reset               (reset),
        .iobus_iob_poweron   (poweron),
        .iobus_iob_reset     (iob_reset),
        .iobus_datao_clear   (stb[DC]),
        .iobus_datao_set     (stb[DS]),
        .iobus_cono_clear    (stb[CC]),
        .iobus_cono_set      (stb[CS]),
        .iobus_iob_fm_datai  (fm_datai),
        .iobus_iob_fm_status (fm_status),
        .iobus_rdi_pulse     (rdi_pulse),
        .iobus_ios           (ios),
        .iobus_iob_in        (iob_in),
        .iobus_pi_req        (pi_req),
        .iobus_iob_out       (iob_out),
        .key_tape_feed       (key),
        .s_read              (s_read),
        .s_readdata          (s_readdata),
        .fe_data_rq          (fe_data_rq)
    );

    // Behavioural model state
    logic [3:0] m_prev = 4'd0;
    logic [3:0] m_pulse = 4'd0;
    logic [2:0] m_pia = 3'd0;
    logic       m_done = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_bin = 1'b0;
    logic [7:0] m_pb = 8'd0;
    int         m_mode = 0;      // 0 waiting, 1 frame offered, 2 punching
    int         m_left = 0;
    logic [8:0] m_frame = 9'd0;
    logic       m_pend = 1'b0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] enc(input logic [7:0] pb, input logic bin);
        return bin ? (9'h080 | {3'b000, pb[5:0]}) : {1'b0, pb};
    endfunction

    task automatic model_clear();
        m_pia = 3'd0; m_done = 1'b0; m_busy = 1'b0; m_bin = 1'b0; m_pb = 8'd0;
        m_mode = 0; m_left = 0; m_frame = 9'd0; m_pend = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] lvl;
        logic [3:0] act;
        logic [5:0] d6;
        logic       old_busy;
        if (!reset) begin
            m_prev = 4'd0;
            m_pulse = 4'd0;
            model_clear();
            return;
        end
        lvl = (ios == PTP) ? stb : 4'd0;
        act = m_pulse;
        m_pulse = lvl & ~m_prev;
        m_prev = lvl;
        if (!poweron || iob_reset) begin
            model_clear();
            return;
        end
        d6 = iob_in[30:35];
        old_busy = m_busy;
        if (act[CC]) {m_bin, m_busy, m_done, m_pia} = 6'd0;
        if (act[CS]) {m_bin, m_busy, m_done, m_pia} = {m_bin, m_busy, m_done, m_pia} | d6;
        if (act[DC]) begin m_pb = 8'd0; m_done = 1'b0; end
        if (act[DS]) begin m_pb = m_pb | iob_in[28:35]; m_busy = 1'b1; end
        case (m_mode)
            0: begin
                if (act[DS]) begin m_frame = enc(m_pb, m_bin); m_mode = 1; end
                else if (key && !old_busy) begin m_frame = 9'h100; m_mode = 1; end
            end
            1: begin
                if (act[DS]) m_pend = 1'b1;
                if (s_read) begin m_mode = 2; m_left = PUNCH; end
            end
            default: begin
                if (act[DS]) m_pend = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    if (m_pend) begin
                        m_pend = 1'b0;
                        m_frame = enc(m_pb, m_bin);
                        m_mode = 1;
                    end else begin
                        m_busy = 1'b0;
                        if (!m_frame[8]) m_done = 1'b1;
                        m_mode = 0;
                    end
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            model_step();
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        logic       clr;
        logic       e_rq;
        logic [6:0] e_pi;
        logic [35:0] e_out;
        forever begin
            @(negedge clk);
            if (running) begin
                clr = !poweron || iob_reset;
                e_rq = !clr && (m_mode == 1);
                e_pi = (!clr && m_done && m_pia != 3'd0) ? 7'(1 << (7 - int'(m_pia))) : 7'd0;
                e_out = (!clr && fm_status && ios == PTP) ? 36'({m_bin, m_busy, m_done, m_pia})
                                                          : 36'd0;
                chk("rq", 36'(fe_data_rq), 36'(e_rq));
                chk("rdata", 36'(s_readdata), e_rq ? 36'(m_frame) : 36'd0);
                chk("pi_req", 36'(pi_req), 36'(e_pi));
                chk("iob_out", 36'(iob_out), e_out);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int which, input logic [35:0] data, input logic [6:0] dev);
        ios = dev;
        iob_in = data;
        stb[which] = 1'b1;
        tick(3);
        stb[which] = 1'b0;
        tick(1);
    endtask

    task automatic pulse_read();
        s_read = 1'b1;
        tick(1);
        s_read = 1'b0;
    endtask

    initial begin
        int feeds;
        tick(3);
        ios = PTP;
        fm_status = 1'b1;
        @(negedge clk);
        chk("reset_rq", 36'(fe_data_rq), 36'd0);
        chk("reset_out", 36'(iob_out), 36'd0);
        tick(1);
        reset = 1'b1;
        tick(2);

        strobe(CC, {18'o0, 18'o060}, PTP);
        strobe(CS, {18'o0, 18'o060}, PTP);
        @(negedge clk);
        chk("coni_bin", 36'(iob_out), 36'o60);
        chk("pi_idle", 36'(pi_req), 36'd0);

        strobe(CC, 36'd0, PTP);
        strobe(CS, 36'o3, PTP);
        strobe(DC, 36'd0, PTP);
        @(negedge clk);
        chk("coni_pia3", 36'(iob_out), 36'o3);

        // DATAO latency: pulse registered one edge after the strobe, frame the edge after
        tick(1);
        iob_in = 36'o134;
        stb[DS] = 1'b1;
        @(negedge clk);
        chk("lat0", 36'(fe_data_rq), 36'd0);
        @(negedge clk);
        chk("lat1", 36'(fe_data_rq), 36'd0);
        @(negedge clk);
        chk("lat2", 36'(fe_data_rq), 36'd1);
        chk("data_134", 36'(s_readdata), 36'h05C);
        tick(1);
        stb[DS] = 1'b0;
        pulse_read();
        repeat (16) @(negedge clk);
        chk("punch_15", 36'(pi_req), 36'd0);
        @(negedge clk);
        chk("punch_16", 36'(pi_req), 36'b0010000);
        chk("coni_done", 36'(iob_out), 36'o13);

        strobe(CS, 36'o40, PTP);
        strobe(DC, 36'd0, PTP);
        strobe(DS, 36'o372, PTP);
        @(negedge clk);
        chk("data_372", 36'(s_readdata), 36'h0BA);
        chk("coni_busy", 36'(iob_out), 36'o63);
        tick(1);
        pulse_read();
        tick(20);

        strobe(DC, 36'd0, PTP);
        key = 1'b1;
        feeds = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (fe_data_rq) begin
                chk("feed_frame", 36'(s_readdata), 36'h100);
                feeds++;
                tick(1);
                pulse_read();
            end
        end
        chk("feed_count", 36'(feeds >= 2), 36'd1);
        tick(1);
        key = 1'b0;
        tick(2);
        if (fe_data_rq) pulse_read();
        tick(20);
        @(negedge clk);
        chk("feed_no_done", 36'(iob_out), 36'o43);

        // DATAO set and feed key reach an idle controller on the same edge
        tick(1);
        strobe(DC, 36'd0, PTP);
        iob_in = 36'o017;
        stb[DS] = 1'b1;
        tick(1);
        key = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("datao_beats_feed", 36'(s_readdata), 36'h08F);
        tick(1);
        key = 1'b0;
        stb[DS] = 1'b0;
        pulse_read();
        tick(20);

        strobe(DS, 36'o5, PTP);
        pulse_read();
        tick(5);
        iob_reset = 1'b1;
        @(negedge clk);
        chk("busrst_rq", 36'(fe_data_rq), 36'd0);
        tick(1);
        iob_reset = 1'b0;
        @(negedge clk);
        chk("busrst_out", 36'(iob_out), 36'd0);
        chk("busrst_pi", 36'(pi_req), 36'd0);
        tick(1);
        pulse_read();
        tick(3);
        @(negedge clk);
        chk("busrst_read", 36'(fe_data_rq), 36'd0);

        tick(1);
        strobe(CS, 36'o77, PTR);
        strobe(DS, 36'o5, PTR);
        @(negedge clk);
        chk("ptr_out", 36'(iob_out), 36'd0);
        chk("ptr_rq", 36'(fe_data_rq), 36'd0);
        tick(1);
        ios = PTP;
        @(negedge clk);
        chk("ptr_nochange", 36'(iob_out), 36'd0);

        for (int i = 0; i < 4000; i++) begin
            tick(1);
            ios = ($urandom_range(0, 9) == 0) ? PTR : PTP;
            iob_in = {4'($urandom()), $urandom()};
            for (int k = 0; k < 4; k++) stb[k] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) key = ~key;
            s_read = ($urandom_range(0, 3) == 0);
            iob_reset = ($urandom_range(0, 499) == 0);
            poweron = ($urandom_range(0, 799) != 0);
            fm_status = 1'($urandom_range(0, 1));
            fm_datai = 1'($urandom_range(0, 1));
            rdi_pulse = 1'($urandom_range(0, 1));
            if (i == 2000) reset = 1'b0;
            if (i == 2002) reset = 1'b1;
        end
        tick(2);
        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ptp_ka10.md
Name: ptp_ka10

Overview:
- Paper tape punch controller on the KA10 I/O bus: the output-direction counterpart of the paper tape reader (ptr_ka10).
- Accepts DATAO words from the processor and presents each one as a punched frame to a host-side consumer over a read handshake.
- Paces completions by a punch-cycle timer, then raises done and a PI request.
- Sits beside ptr_ka10 on the same iobus and uses the same bus port set.

Parameters:
- DEVCODE, 7'b0010000, device code 100 octal, compared against iobus_ios[3:9].
- PUNCH_CYCLES, 16, clk cycles from host frame consumption to done (mechanical punch time).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- iobus_iob_poweron  in  1  low forces reset state
- iobus_iob_reset  in  1  bus reset, clears status and buffer
- iobus_datao_clear  in  1  DATAO clear phase
- iobus_datao_set  in  1  DATAO set phase
- iobus_cono_clear  in  1  CONO clear phase
- iobus_cono_set  in  1  CONO set phase
- iobus_iob_fm_datai  in  1  DATAI strobe; punch returns 0
- iobus_iob_fm_status  in  1  CONI strobe
- iobus_rdi_pulse  in  1  ignored, kept for bus uniformity
- iobus_ios  in  [3:9]  device select
- iobus_iob_in  in  [0:35]  bus data to device
- iobus_pi_req  out  [1:7]  PI request, one-hot by PIA
- iobus_iob_out  out  [0:35]  CONI data, 0 when not selected
- key_tape_feed  in  1  front-panel feed key, punches blank leader
- s_read  in  1  host consumes current frame (one-cycle pulse)
- s_readdata  out  32  [7:0] frame holes 8..1, [8] feed frame, [31:9] 0
- fe_data_rq  out  1  frame available for host

Behaviour:
- sel = (iobus_ios == DEVCODE).
- All bus strobes act once, on the rising edge of the strobe while sel; a held level does not re-trigger.
- Status bits:
  - PIA = iob_in[33:35]
  - done = [32]
  - busy = [31]
  - binary = [30]
  - CONI drives these bits at the same positions; all other bits are 0.
- CONO clear: PIA, done, busy and binary all go to 0. CONO set: ORs iob_in[30:35] into the same bits.
- DATAO clear: pb (8-bit punch buffer) = 0, done = 0. DATAO set: pb |= iob_in[28:35], busy = 1, state goes LOADED.
- Frame encoding:
  - binary = 1: frame = {1'b1, 1'b0, pb[5:0]} (hole 8 always punched).
  - binary = 0: frame = pb.
- States:
  - IDLE: waiting for work.
  - LOADED: fe_data_rq = 1 and s_readdata is valid.
    - s_read moves to PUNCH and loads the timer with PUNCH_CYCLES-1.
  - PUNCH: timer decrements each cycle; at 0, busy = 0, done = 1 (a feed frame does not set done), then IDLE.
- Feed:
  - In IDLE with key_tape_feed = 1 and busy = 0: load frame 0 with feed flag = 1, go LOADED.
  - Feed repeats while the key is held.
  - DATAO set in the same cycle wins; feed is ignored that cycle.
- DATAO set while LOADED or PUNCH:
  - Overwrites/ORs pb for the next frame only.
  - Does not restart the timer.
  - The frame is re-presented after the current PUNCH completes, without setting done twice.
- PI request: iobus_pi_req = done && PIA != 0 ? (7'b1000000 >> (PIA-1)) : 0. Combinational from registered state.
- Reset (reset = 0, iobus_iob_reset = 1, or iobus_iob_poweron = 0):
  - All status bits, pb and timer are 0; state goes IDLE.
  - fe_data_rq = 0, s_readdata = 0, iobus_pi_req = 0, iobus_iob_out = 0.
  - Mid-operation reset abandons the frame; a pending s_read is ignored.
- s_read outside LOADED is ignored.
- Output latency: fe_data_rq rises the cycle after the DATAO set edge is registered.

Decomposition:
- Shared package ka10_io_pkg:
  - device codes (PTR 104, PTP 100)
  - CONI/CONO bit positions: PIA, done, busy, binary
  - PI one-hot decode function
  - frame field positions
- One sub-module, iob_edge: rising-edge pulse generator with async active-low reset, instantiated per strobe. Shared with ptr_ka10.

Test Plan:
- Reset, then CONO clear/set with iob_in = {18'o0, 18'o060}, ios = 0010000 -> CONI reads PIA 0, binary 1 (bit 30); pi_req = 0.
- CONO PIA = 3, binary = 0; DATAO 'o134 -> fe_data_rq next cycle, s_readdata = 'h05C; s_read -> after 16 cycles done = 1, busy = 0, pi_req = 7'b0010000.
- binary = 1, DATAO 'o372 -> s_readdata = 'h0BA (hole 8 set, hole 7 clear).
- key_tape_feed held with busy = 0 -> repeated s_readdata = 'h100 frames, done never set; DATAO set in the same cycle as feed -> data frame presented first.
- iobus_iob_reset pulsed during PUNCH -> fe_data_rq = 0, busy = 0, done = 0, pi_req = 0; subsequent s_read has no effect.
- ios = 0010001 (PTR code) with DATAO/CONO/CONI -> no state change, iob_out = 0.
